// File: rtl/lm80c_sio_pkg.sv
// Shared constants and types for the LM80C serial I/O block.
package lm80c_sio_pkg;

    localparam logic [2:0] CMD_CHAN_RESET = 3'b011;
    localparam logic [2:0] CMD_RST_TXINT  = 3'b101;
    localparam logic [2:0] CMD_ERR_RESET  = 3'b110;

    localparam int RR0_RX_AVAIL = 0;
    localparam int RR0_TX_EMPTY = 2;
    localparam int RR1_ALL_SENT = 0;
    localparam int RR1_OVERRUN  = 5;
    localparam int RR1_FRAMING  = 6;

    localparam logic [7:0] CHB_CTRL_VALUE = 8'h04;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_e;

endpackage

// File: rtl/lm80c_sio_rx.sv
// 8N1 receiver: rxd synchronizer, bit-centre sampling FSM, one-cycle byte_valid pulse.
//  state | meaning
//  IDLE  | waiting for a falling edge on the synchronized line
//  START | counting to mid start bit; line high there means a glitch
//  DATA  | sampling d0..d7 at bit centres
//  STOP  | sampling the stop bit, then reporting the byte
module lm80c_sio_rx
    import lm80c_sio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       sys_clock,
    input  logic       RESET,
    input  logic       i_clear,
    input  logic       i_rxd,
    output logic       o_byte_valid,
    output logic       o_framing_err,
    output logic [7:0] o_data
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_line_prev;
    ser_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_tc;
    logic          w_fall;

    assign w_tc   = (r_cnt == '0);
    assign w_fall = r_line_prev & ~r_sync2;

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_line_prev <= 1'b1;
        end else begin
            r_sync1     <= i_rxd;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET || i_clear) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            o_byte_valid  <= 1'b0;
            o_framing_err <= 1'b0;
            o_data        <= '0;
        end else begin
            o_byte_valid  <= 1'b0;
            o_framing_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= HALF_M1;
                    end
                end
                START: begin
                    if (w_tc) begin
                        if (r_sync2) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA;
                            r_cnt   <= FULL_M1;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (w_tc) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= FULL_M1;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                STOP: begin
                    if (w_tc) begin
                        o_byte_valid  <= 1'b1;
                        o_framing_err <= ~r_sync2;
                        o_data        <= r_shift;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lm80c_sio.sv
// Reduced Z80-SIO channel A for the LM80C: bus interface, register file, 8N1 transmitter.
//  state | meaning (TX)
//  IDLE  | line high, waiting for the holding register to fill
//  START | driving the start bit
//  DATA  | shifting d0..d7 out LSB first
//  STOP  | driving the stop bit; a full holding register chains straight into START
module lm80c_sio
    import lm80c_sio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       sys_clock,
    input  logic       RESET,
    input  logic       ce_n,
    input  logic       cd,
    input  logic       ba,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       int_n,
    input  logic       rxd,
    output logic       txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          r_rd_prev;
    logic          r_wr_prev;
    logic          w_rd_start;
    logic          w_rd_end;
    logic          w_wr_start;
    logic          r_rd_data_a;
    logic          r_rd_ctrl_a;
    logic          w_wr_data_a;
    logic          w_wr_ctrl_a;
    logic          w_wr0;
    logic [2:0]    w_cmd;
    logic          w_chan_reset;
    logic          w_err_reset;
    logic          w_rst_txint;
    logic          w_pop;

    logic [2:0]    r_ptr;
    logic          r_rx_ie;
    logic          r_tx_ie;

    logic [7:0]    r_rx_buf;
    logic          r_rx_avail;
    logic          r_overrun;
    logic          r_framing;
    logic          w_byte_valid;
    logic          w_framing_err;
    logic [7:0]    w_rx_data;

    logic [7:0]    r_tx_hold;
    logic          r_tx_empty;
    logic          r_tx_int_pending;
    ser_state_e    r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_txd;
    logic          w_tx_tc;
    logic          w_tx_load;
    logic          w_all_sent;

    logic [7:0]    w_rr0;
    logic [7:0]    w_rr1;

    assign w_rd_acc   = ~ce_n & ~iorq_n & ~rd_n;
    assign w_wr_acc   = ~ce_n & ~iorq_n & ~wr_n;
    assign w_rd_start = w_rd_acc & ~r_rd_prev;
    assign w_rd_end   = ~w_rd_acc & r_rd_prev;
    assign w_wr_start = w_wr_acc & ~r_wr_prev;

    assign w_wr_data_a  = w_wr_start & ~cd & ~ba;
    assign w_wr_ctrl_a  = w_wr_start & cd & ~ba;
    assign w_wr0        = w_wr_ctrl_a & (r_ptr == 3'd0);
    assign w_cmd        = din[5:3];
    assign w_chan_reset = w_wr0 & (w_cmd == CMD_CHAN_RESET);
    assign w_err_reset  = w_wr0 & (w_cmd == CMD_ERR_RESET);
    assign w_rst_txint  = w_wr0 & (w_cmd == CMD_RST_TXINT);
    assign w_pop        = w_rd_end & r_rd_data_a;

    // Read side effects wait for the end of the access so dout holds for the whole CPU read.
    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            r_rd_prev   <= 1'b0;
            r_wr_prev   <= 1'b0;
            r_rd_data_a <= 1'b0;
            r_rd_ctrl_a <= 1'b0;
        end else begin
            r_rd_prev <= w_rd_acc;
            r_wr_prev <= w_wr_acc;
            if (w_rd_start) begin
                r_rd_data_a <= ~cd & ~ba;
                r_rd_ctrl_a <= cd & ~ba;
            end else if (w_rd_end) begin
                r_rd_data_a <= 1'b0;
                r_rd_ctrl_a <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET || w_chan_reset) begin
            r_ptr   <= '0;
            r_rx_ie <= 1'b0;
            r_tx_ie <= 1'b0;
        end else if (w_wr_ctrl_a) begin
            if (r_ptr == 3'd0) begin
                r_ptr <= din[2:0];
            end else begin
                if (r_ptr == 3'd1) begin
                    r_rx_ie <= |din[4:3];
                    r_tx_ie <= din[1];
                end
                r_ptr <= '0;
            end
        end else if (w_rd_end && r_rd_ctrl_a) begin
            r_ptr <= '0;
        end
    end

    lm80c_sio_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .sys_clock     (sys_clock),
        .RESET         (RESET),
        .i_clear       (w_chan_reset),
        .i_rxd         (rxd),
        .o_byte_valid  (w_byte_valid),
        .o_framing_err (w_framing_err),
        .o_data        (w_rx_data)
    );

    always_ff @(posedge sys_clock) begin
        if (RESET || w_chan_reset) begin
            r_rx_buf   <= '0;
            r_rx_avail <= 1'b0;
            r_overrun  <= 1'b0;
            r_framing  <= 1'b0;
        end else begin
            if (w_err_reset) begin
                r_overrun <= 1'b0;
                r_framing <= 1'b0;
            end
            // A byte landing on the pop cycle replaces the one being read without overrun.
            if (w_byte_valid) begin
                if (r_rx_avail && !w_pop) begin
                    r_overrun <= 1'b1;
                end
                r_rx_buf   <= w_rx_data;
                r_rx_avail <= 1'b1;
                r_framing  <= w_framing_err;
            end else if (w_pop) begin
                r_rx_avail <= 1'b0;
            end
        end
    end

    assign w_tx_tc   = (r_tx_cnt == '0);
    assign w_tx_load = ~r_tx_empty & ((r_tx_state == IDLE) | ((r_tx_state == STOP) & w_tx_tc));

    always_ff @(posedge sys_clock) begin
        if (RESET || w_chan_reset) begin
            r_tx_state       <= IDLE;
            r_tx_cnt         <= '0;
            r_tx_bit         <= '0;
            r_tx_shift       <= '0;
            r_txd            <= 1'b1;
            r_tx_hold        <= '0;
            r_tx_empty       <= 1'b1;
            r_tx_int_pending <= 1'b0;
        end else begin
            if (w_tx_load) begin
                r_tx_shift       <= r_tx_hold;
                r_txd            <= 1'b0;
                r_tx_cnt         <= FULL_M1;
                r_tx_state       <= START;
                r_tx_empty       <= 1'b1;
                r_tx_int_pending <= 1'b1;
            end else begin
                case (r_tx_state)
                    IDLE: r_txd <= 1'b1;
                    START: begin
                        if (w_tx_tc) begin
                            r_tx_state <= DATA;
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_cnt   <= FULL_M1;
                            r_tx_bit   <= '0;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - CW'(1);
                        end
                    end
                    DATA: begin
                        if (w_tx_tc) begin
                            r_tx_cnt <= FULL_M1;
                            if (r_tx_bit == 3'd7) begin
                                r_tx_state <= STOP;
                                r_txd      <= 1'b1;
                            end else begin
                                r_tx_bit   <= r_tx_bit + 3'd1;
                                r_txd      <= r_tx_shift[0];
                                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt - CW'(1);
                        end
                    end
                    STOP: begin
                        if (w_tx_tc) begin
                            r_tx_state <= IDLE;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - CW'(1);
                        end
                    end
                    default: r_tx_state <= IDLE;
                endcase
            end
            if (w_wr_data_a) begin
                r_tx_hold        <= din;
                r_tx_empty       <= 1'b0;
                r_tx_int_pending <= 1'b0;
            end
            if (w_rst_txint) begin
                r_tx_int_pending <= 1'b0;
            end
        end
    end

    assign w_all_sent = (r_tx_state == IDLE) & r_tx_empty;

    always_comb begin
        w_rr0 = 8'h00;
        w_rr0[RR0_RX_AVAIL] = r_rx_avail;
        w_rr0[RR0_TX_EMPTY] = r_tx_empty;
        w_rr1 = 8'h00;
        w_rr1[RR1_ALL_SENT] = w_all_sent;
        w_rr1[RR1_OVERRUN]  = r_overrun;
        w_rr1[RR1_FRAMING]  = r_framing;
    end

    always_comb begin
        dout = 8'h00;
        if (w_rd_acc) begin
            case ({cd, ba})
                2'b00: dout = r_rx_buf;
                2'b10: begin
                    case (r_ptr)
                        3'd0:    dout = w_rr0;
                        3'd1:    dout = w_rr1;
                        default: dout = 8'h00;
                    endcase
                end
                2'b11:   dout = CHB_CTRL_VALUE;
                default: dout = 8'h00;
            endcase
        end
    end

    assign txd   = r_txd;
    assign int_n = ~((r_rx_avail & r_rx_ie) | (r_tx_int_pending & r_tx_ie));

endmodule
